// File: rtl/pp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pp_pkg
//  Description : Shared definitions for the pattern-detector FSMs and the
//                pp_stim_gen sequence transmitter: state encoding, state
//                width, hold-counter width and default (x,y) symbols.
//  Revision    : 1.0  initial release
// ============================================================================
package pp_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        S0    = 3'd1,
        S1    = 3'd2,
        S2    = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } pp_state_t;

    // Default walk SA->SB->SC->SD, symbols given as {x,y}
    localparam logic [1:0] SYM_A = 2'b10;
    localparam logic [1:0] SYM_B = 2'b01;
    localparam logic [1:0] SYM_C = 2'b00;

endpackage : pp_pkg
`default_nettype wire

// File: rtl/pp_hold_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pp_hold_cnt
//  Description : 8-bit loadable down-counter used to time how long each
//                symbol is held. Load has priority over decrement; the
//                counter saturates at zero.
//  Ports       : clk        - rising-edge clock
//                rst        - asynchronous active-high reset (count -> 0)
//                i_load     - load i_load_val on the next edge
//                i_load_val - reload value
//                i_dec      - decrement on the next edge (ignored at zero)
//                o_zero     - count is zero
//  Revision    : 1.0  initial release
// ============================================================================
module pp_hold_cnt
    import pp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : pp_hold_cnt
`default_nettype wire

// File: rtl/pp_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pp_stim_gen
//  Description : Sequence transmitter for the Moore pattern detectors. On a
//                start request it drives SYM0, SYM1, SYM2 onto {x,y}, each
//                for HOLD_CYCLES clocks, then samples the detector output q
//                and reports a sticky pass/fail.
//  Macro       : PP_STIM_CHECK_EN - when defined the CHECK state samples q;
//                when undefined S2 goes straight to DONE, q is ignored and
//                pass/fail are tied low.
//  Ports       : Clk   - rising-edge clock
//                Rst   - asynchronous active-high reset
//                start - launch request, honoured only in IDLE
//                q     - detector output
//                x, y  - registered detector inputs
//                busy  - high from S0 through DONE
//                done  - one-cycle pulse while in DONE
//                pass  - sticky result of last check, cleared on launch
//                fail  - sticky complement of pass, cleared on launch
//  Revision    : 1.0  initial release
// ============================================================================
module pp_stim_gen
    import pp_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter logic [1:0]  SYM0        = SYM_A,
    parameter logic [1:0]  SYM1        = SYM_B,
    parameter logic [1:0]  SYM2        = SYM_C,
    parameter logic        EXP_Q       = 1'b1
)(
    input  logic Clk,
    input  logic Rst,
    input  logic start,
    input  logic q,
    output logic x,
    output logic y,
    output logic busy,
    output logic done,
    output logic pass,
    output logic fail
);

    localparam logic [CNT_W-1:0] c_hold_reload = CNT_W'(HOLD_CYCLES - 1);

    pp_state_t   r_state;
    pp_state_t   w_next_state;
    logic [1:0]  r_xy;
    logic [1:0]  w_xy_next;
    logic        r_busy;
    logic        r_done;
    logic        w_launch;
    logic        w_check;
    logic        w_load;
    logic        w_dec;
    logic        w_cnt_zero;

    pp_hold_cnt u_hold_cnt (
        .clk        (Clk),
        .rst        (Rst),
        .i_load     (w_load),
        .i_load_val (c_hold_reload),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    assign w_launch = (r_state == IDLE) && start;

    // Next-state, counter control and next-output decode.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_check      = 1'b0;
        w_xy_next    = 2'b00;

        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_next_state = S0;
                    w_load       = 1'b1;
                end
            end
            S0: begin
                if (w_cnt_zero) begin
                    w_next_state = S1;
                    w_load       = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S1: begin
                if (w_cnt_zero) begin
                    w_next_state = S2;
                    w_load       = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S2: begin
                if (w_cnt_zero) begin
`ifdef PP_STIM_CHECK_EN
                    w_next_state = CHECK;
`else
                    w_next_state = DONE;
`endif
                    w_load       = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
`ifdef PP_STIM_CHECK_EN
            CHECK: begin
                w_check      = 1'b1;
                w_next_state = DONE;
            end
`endif
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register
        // alongside the state and never glitch.
        case (w_next_state)
            S0:      w_xy_next = SYM0;
            S1:      w_xy_next = SYM1;
            S2:      w_xy_next = SYM2;
            default: w_xy_next = 2'b00;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
            r_xy    <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_xy    <= w_xy_next;
            r_busy  <= (w_next_state != IDLE);
            r_done  <= (w_next_state == DONE);
        end
    end

    assign x    = r_xy[1];
    assign y    = r_xy[0];
    assign busy = r_busy;
    assign done = r_done;

`ifdef PP_STIM_CHECK_EN
    logic r_pass;
    logic r_fail;

    // q is sampled at the edge that closes CHECK; an aborted run (reset)
    // leaves both flags at their cleared value.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_launch) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_check) begin
            r_pass <= (q == EXP_Q);
            r_fail <= (q != EXP_Q);
        end
    end

    assign pass = r_pass;
    assign fail = r_fail;
`else
    // Check disabled: q and the compare value have no effect.
    logic w_unused_chk;
    assign w_unused_chk = ^{q, w_check, EXP_Q};

    assign pass = 1'b0;
    assign fail = 1'b0;
`endif

endmodule : pp_stim_gen
`default_nettype wire

// File: tb/tb_pp_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pp_stim_gen
//  Description : Self-checking bench for pp_stim_gen. Two instances
//                (HOLD_CYCLES 1 and 3) share clock and reset. Outputs are
//                compared as a 6-bit vector {x,y,busy,done,pass,fail}
//                against a table and against a timeline model derived from
//                the launch edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pp_stim_gen;

`ifdef PP_STIM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst;
    logic start0, q0, start1, q1;
    logic x0, y0, busy0, done0, pass0, fail0;
    logic x1, y1, busy1, done1, pass1, fail1;

    int checks = 0;
    int errors = 0;
    logic [1:0] last_pf [2];

    always #5 Clk = ~Clk;

    pp_stim_gen #(.HOLD_CYCLES(1)) dut0 (
        .Clk(Clk), .Rst(Rst), .start(start0), .q(q0),
        .x(x0), .y(y0), .busy(busy0), .done(done0), .pass(pass0), .fail(fail0)
    );

    pp_stim_gen #(.HOLD_CYCLES(3)) dut1 (
        .Clk(Clk), .Rst(Rst), .start(start1), .q(q1),
        .x(x1), .y(y1), .busy(busy1), .done(done1), .pass(pass1), .fail(fail1)
    );

    typedef struct {
        bit         st;
        bit         qq;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [5:0] outs(input int d);
        if (d == 0) return {x0, y0, busy0, done0, pass0, fail0};
        else        return {x1, y1, busy1, done1, pass1, fail1};
    endfunction

    function automatic logic [1:0] sym_of(input int i);
        case (i)
            0:       return 2'b10;
            1:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic set_in(input int d, input bit s, input bit qq);
        if (d == 0) begin start0 = s; q0 = qq; end
        else        begin start1 = s; q1 = qq; end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {x,y,busy,done,pass,fail}=%b expected %b", name, act, exp);
        end
    endtask

    // Timeline model: state after the launch edge k+t is fully determined
    // by t and H. mode 0: single start pulse; 1: extra pulse while in S1;
    // 2: start held high throughout; 3: random start while busy.
    task automatic run_model(input int d, input int H, input int mode);
        int         L;
        bit         s;
        bit         qq;
        logic [1:0] pf;
        logic [5:0] exp;
        L  = 3 * H + int'(CHK) + 2;
        pf = 2'b00;
        set_in(d, 1'b1, 1'($urandom_range(1, 0)));
        tick();
        for (int t = 0; t < L; t++) begin
            if (t < 3 * H)
                exp = {sym_of(t / H), 1'b1, 1'b0, 2'b00};
            else if (CHK && t == 3 * H)
                exp = 6'b001000;
            else if (t == 3 * H + int'(CHK))
                exp = {2'b00, 1'b1, 1'b1, pf};
            else
                exp = {4'b0000, pf};
            chk($sformatf("run d%0d H%0d m%0d t%0d", d, H, mode, t), outs(d), exp);
            case (mode)
                0:       s = 1'b0;
                1:       s = (t == H);
                2:       s = 1'b1;
                default: s = (t < L - 1) ? 1'($urandom_range(1, 0)) : 1'b0;
            endcase
            qq = 1'($urandom_range(1, 0));
            if (t == 3 * H)
                pf = CHK ? (qq ? 2'b10 : 2'b01) : 2'b00;
            set_in(d, s, qq);
            if (t < L - 1) tick();
        end
        last_pf[d] = pf;
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            set_in(d, 1'b0, 1'($urandom_range(1, 0)));
            tick();
            chk($sformatf("idle d%0d c%0d", d, i), outs(d), {4'b0000, last_pf[d]});
        end
    endtask

    initial begin
        // Two H=1 runs: first with q=1 at the closing CHECK edge, then q=0.
        // q is the opposite value on neighbouring edges so a shifted sample
        // point shows up.
        for (int r = 0; r < 2; r++) begin
            bit         qc;
            logic [1:0] pf;
            int         b;
            qc = (r == 0);
            pf = CHK ? (qc ? 2'b10 : 2'b01) : 2'b00;
            b  = r * 6;
            tbl[b + 0] = '{1'b1, 1'b0, 6'b101000};
            tbl[b + 1] = '{1'b0, 1'b0, 6'b011000};
            tbl[b + 2] = '{1'b0, 1'b0, 6'b001000};
            tbl[b + 3] = '{1'b0, !qc,  CHK ? 6'b001000 : 6'b001100};
            tbl[b + 4] = '{1'b0, qc,   CHK ? {4'b0011, pf} : 6'b000000};
            tbl[b + 5] = '{1'b0, !qc,  {4'b0000, pf}};
        end

        Rst = 1'b1;
        set_in(0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0);
        last_pf[0] = 2'b00;
        last_pf[1] = 2'b00;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset d0", outs(0), 6'b000000);
        chk("reset d1", outs(1), 6'b000000);
        @(negedge Clk);
        Rst = 1'b0;
        tick();
        chk("post-reset d0", outs(0), 6'b000000);
        chk("post-reset d1", outs(1), 6'b000000);

        for (int i = 0; i < 12; i++) begin
            set_in(0, tbl[i].st, tbl[i].qq);
            tick();
            chk($sformatf("table row %0d", i), outs(0), tbl[i].exp);
        end
        last_pf[0] = CHK ? 2'b01 : 2'b00;
        idle(0, 2);

        // H=3: plain run, then a start pulse during S1 that must be ignored.
        run_model(1, 3, 0);
        idle(1, 1);
        run_model(1, 3, 1);
        idle(1, 2);

        // start held through DONE: no early relaunch, then earliest relaunch.
        run_model(0, 1, 2);
        run_model(0, 1, 0);
        idle(0, 1);

        // Reset during S2 aborts the run at once.
        set_in(1, 1'b1, 1'b0);
        tick();
        set_in(1, 1'b0, 1'b0);
        repeat (6) tick();
        chk("abort in S2", outs(1), 6'b001000);
        #2 Rst = 1'b1;
        #1;
        chk("async abort d1", outs(1), 6'b000000);
        chk("async abort d0", outs(0), 6'b000000);
        @(negedge Clk);
        Rst = 1'b0;
        last_pf[0] = 2'b00;
        last_pf[1] = 2'b00;
        idle(1, 4);
        run_model(1, 3, 0);

        // Randomised runs on both instances with random gaps.
        for (int i = 0; i < 24; i++) begin
            int d;
            d = int'($urandom_range(1, 0));
            run_model(d, (d == 1) ? 3 : 1, 3);
            idle(d, int'($urandom_range(2, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pp_stim_gen
`default_nettype wire

// File: doc/pp_stim_gen.md
# pp_stim_gen

Sequence transmitter for the Moore pattern-detector FSMs in this design. On a start request it drives a fixed three-symbol (x,y) sequence onto the detector inputs, one symbol per HOLD_CYCLES clocks, which walks the detector SA->SB->SC->SD. It then samples the detector output q and reports pass/fail. It replaces hand-written bench stimulus and serves as an on-chip self-test driver.

## Interface
Parameters:
- HOLD_CYCLES, 1: clocks each symbol is held; legal range 1..255.
- SYM0, 2'b10: first symbol as {x,y}.
- SYM1, 2'b01: second symbol as {x,y}.
- SYM2, 2'b00: third symbol as {x,y}.
- EXP_Q, 1'b1: q value the detector must present after the third symbol.

Ports:
- Clk  input  1  single clock, rising-edge.
- Rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled request; acted on only in IDLE.
- q  input  1  detector output (Moore, combinational from detector state).
- x  output  1  detector input x, registered.
- y  output  1  detector input y, registered.
- busy  output  1  high from S0 through DONE.
- done  output  1  one-cycle pulse in DONE.
- pass  output  1  sticky result of the last check; cleared on next start.
- fail  output  1  sticky complement of pass after a check; cleared on next start.

## Operation
- States: IDLE, S0, S1, S2, CHECK, DONE. Encoded 3-bit.
- IDLE: {x,y}=00, busy=0. If start=1 at a rising edge, go to S0, load the hold counter with HOLD_CYCLES-1, and clear pass and fail.
- S0/S1/S2: {x,y}=SYM0/SYM1/SYM2. The hold counter decrements each edge. When the counter is 0 at an edge, advance to the next state and reload the counter. S2 advances to CHECK.
- CHECK: {x,y}=00 for exactly one cycle. At the closing edge, compare q with EXP_Q: match sets pass=1, fail=0; mismatch sets pass=0, fail=1. Go to DONE.
- DONE: done=1 for one cycle, busy=1, {x,y}=00. Go to IDLE unconditionally.
- start while busy=1 is ignored; there is no queueing. start held high through DONE relaunches one cycle after IDLE is re-entered.
- All outputs come from flops; x and y never glitch.

## Timing
- Reset (async assert, sync release): state=IDLE, x=0, y=0, busy=0, done=0, pass=0, fail=0, hold counter=0.
- Rst asserted mid-sequence aborts immediately. pass/fail are not updated for the aborted run.
- Let edge k be the edge where start=1 is sampled in IDLE. SYM0 is valid after edge k, SYM1 after k+H, SYM2 after k+2H, and CHECK after k+3H (H=HOLD_CYCLES).
- q is sampled at edge k+3H+1. done=1 during cycle k+3H+1..k+3H+2. IDLE after edge k+3H+2.
- Total start-to-done latency is 3H+1 edges. The earliest relaunch is sampled at edge k+3H+3.
- The detector sees each symbol for H rising edges, so its state after edge k+3H reflects the full sequence.

## Configuration
- PP_STIM_CHECK_EN defined: CHECK state present, and q is compared as described.
- PP_STIM_CHECK_EN undefined:
  - CHECK state is removed, and S2 goes directly to DONE, so latency is 3H edges.
  - q is ignored.
  - pass and fail are tied to 0.
  - The port list is unchanged.

## Structure
- Shared package pp_pkg holds the state typedef/localparams (IDLE..DONE), the default symbol constants SYM_A=2'b10, SYM_B=2'b01, SYM_C=2'b00, and the state width. The detector FSM uses the same package.
- One sub-module, pp_hold_cnt: an 8-bit loadable down-counter with load, dec, and zero outputs.

## Test plan
- Reset then start=1 for one cycle, H=1, detector in loop with correct q: x,y = 10,01,00 on consecutive cycles, then CHECK 00; done at edge k+4; pass=1, fail=0.
- Same as above, but q forced 0 during CHECK: fail=1, pass=0; done still at edge k+4.
- H=3: each symbol is held exactly 3 cycles; done at edge k+10; busy high for 11 cycles.
- start pulsed again during S1: ignored; sequence and done timing are unchanged; exactly one done pulse.
- Rst asserted during S2 for one cycle: x=y=0 and busy=0 immediately; done never pulses; pass and fail stay 0; a following start runs a full, correct sequence.
- With PP_STIM_CHECK_EN undefined, H=1: done at edge k+3; pass=fail=0 regardless of q.
